// File: rtl/ps2_pkg.sv
// PS/2 scancode receiver: shared states and frame constants.
// Build option PS2_PARITY_CHECK_EN enables odd-parity checking.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
   localparam logic [7:0] PS2_REL_PREFIX = 8'hF0;
   localparam int PS2_FRAME_DATA_BITS = 8;

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// PS/2 scancode receiver: decoded key-event bundle
// toward the system block.
interface ps2_scancode_rx_if;

   logic [7:0] scancode;
   logic       extended;
   logic       released;
   logic       kb_interrupt;
   logic       frame_err;

   modport master (
      output scancode, extended, released,
      output kb_interrupt, frame_err
   );

   modport slave (
      input scancode, extended, released,
      input kb_interrupt, frame_err
   );

endinterface

// File: rtl/ps2_scancode_rx_line_filter.sv
// PS/2 line conditioning: pin synchronisers, clock glitch
// filter and falling-edge detect on the filtered clock.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_raw,
   input  logic data_raw,
   output logic data_sync,
   output logic fall
);

   logic [1:0]            clk_ff;
   logic [1:0]            data_ff;
   logic [FILTER_LEN-1:0] hist;
   logic                  filt;
   logic                  filt_next;

   // synchronise pins and shift filter history; idle line is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_ff  <= '1;
         data_ff <= '1;
         hist    <= '1;
         filt    <= 1'b1;
      end else begin
         clk_ff  <= {clk_ff[0], clk_raw};
         data_ff <= {data_ff[0], data_raw};
         hist    <= {hist[FILTER_LEN-2:0], clk_ff[1]};
         filt    <= filt_next;
      end
   end

   // level changes only after FILTER_LEN agreeing samples
   always_comb begin
      filt_next = filt;
      if (hist == '0)
         filt_next = 1'b0;
      else if (&hist)
         filt_next = 1'b1;
   end

   assign fall      = filt & ~filt_next;
   assign data_sync = data_ff[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames and folds E0/F0
// prefixes into flags. Build option: PS2_PARITY_CHECK_EN.
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 28000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clkps2,
   input  logic dataps2,
   ps2_scancode_rx_if.master ev
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0] LAST_BIT = 3'(PS2_FRAME_DATA_BITS - 1);

   logic data;
   logic fall;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk_raw   (clkps2),
      .data_raw  (dataps2),
      .data_sync (data),
      .fall      (fall)
   );

   ps2_state_t    state, state_n;
   logic [2:0]    bitcnt, bitcnt_n;
   logic [7:0]    shreg, shreg_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic          ext_pend, ext_pend_n;
   logic          rel_pend, rel_pend_n;
   logic [7:0]    code_q, code_n;
   logic          ext_q, ext_n;
   logic          rel_q, rel_n;
   logic          int_q, int_n;
   logic          err_q, err_n;
   logic          par_ok;
   logic          deliver;
   logic          drop;

`ifdef PS2_PARITY_CHECK_EN
   logic par, par_n;

   // parity bit is held until the stop bit decides the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         par <= 1'b0;
      else
         par <= par_n;
   end

   always_comb begin
      par_n = par;
      if (fall && state == PARITY)
         par_n = data;
   end

   assign par_ok = ^{shreg, par};
`else
   assign par_ok = 1'b1;
`endif

   // frame, timeout and event registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bitcnt   <= '0;
         shreg    <= '0;
         tcnt     <= '0;
         ext_pend <= 1'b0;
         rel_pend <= 1'b0;
         code_q   <= '0;
         ext_q    <= 1'b0;
         rel_q    <= 1'b0;
         int_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         bitcnt   <= bitcnt_n;
         shreg    <= shreg_n;
         tcnt     <= tcnt_n;
         ext_pend <= ext_pend_n;
         rel_pend <= rel_pend_n;
         code_q   <= code_n;
         ext_q    <= ext_n;
         rel_q    <= rel_n;
         int_q    <= int_n;
         err_q    <= err_n;
      end
   end

   // frame FSM on filtered falls, timeout abort, prefix folding
   always_comb begin
      state_n    = state;
      bitcnt_n   = bitcnt;
      shreg_n    = shreg;
      tcnt_n     = tcnt;
      ext_pend_n = ext_pend;
      rel_pend_n = rel_pend;
      code_n     = code_q;
      ext_n      = ext_q;
      rel_n      = rel_q;
      int_n      = 1'b0;
      err_n      = 1'b0;
      deliver    = 1'b0;
      drop       = 1'b0;

      if (fall || state == IDLE)
         tcnt_n = '0;
      else if (tcnt != '1)
         tcnt_n = tcnt + 1'b1;

      if (!fall) begin
         if (state != IDLE && tcnt == T_LAST) begin
            state_n = IDLE;
            drop    = 1'b1;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (!data) begin
                  state_n  = DATA;
                  bitcnt_n = '0;
               end
            end
            DATA: begin
               shreg_n  = {data, shreg[7:1]};
               bitcnt_n = bitcnt + 1'b1;
               if (bitcnt == LAST_BIT)
                  state_n = PARITY;
            end
            PARITY: state_n = STOP;
            STOP: begin
               state_n = IDLE;
               if (data && par_ok)
                  deliver = 1'b1;
               else
                  drop = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end

      if (drop) begin
         err_n      = 1'b1;
         ext_pend_n = 1'b0;
         rel_pend_n = 1'b0;
      end else if (deliver) begin
         if (shreg == PS2_EXT_PREFIX) begin
            ext_pend_n = 1'b1;
         end else if (shreg == PS2_REL_PREFIX) begin
            rel_pend_n = 1'b1;
         end else begin
            code_n     = shreg;
            ext_n      = ext_pend;
            rel_n      = rel_pend;
            int_n      = 1'b1;
            ext_pend_n = 1'b0;
            rel_pend_n = 1'b0;
         end
      end
   end

   assign ev.scancode     = code_q;
   assign ev.extended     = ext_q;
   assign ev.released     = rel_q;
   assign ev.kb_interrupt = int_q;
   assign ev.frame_err    = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed frames plus random
// prefixed key events against a byte-stream reference model.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

   localparam int FL   = 8;
   localparam int TO   = 28000;
   localparam int HALF = 40;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clkps2 = 1'b1;
   logic dataps2 = 1'b1;

   ps2_scancode_rx_if ev ();

   ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clkps2  (clkps2),
      .dataps2 (dataps2),
      .ev      (ev)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int n_int = 0;
   int n_err = 0;
   int n_both = 0;
   int n_wide = 0;
   logic prev_int = 1'b0;
   logic prev_err = 1'b0;

   // strobe counters sampled away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (ev.kb_interrupt) n_int++;
         if (ev.frame_err) n_err++;
         if (ev.kb_interrupt && ev.frame_err) n_both++;
         if ((ev.kb_interrupt && prev_int) || (ev.frame_err && prev_err))
            n_wide++;
         prev_int = ev.kb_interrupt;
         prev_err = ev.frame_err;
      end else begin
         prev_int = 1'b0;
         prev_err = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b,
                                      input bit flip, input bit stop);
      logic p;
      p = ~(^b) ^ flip;
      return {stop, p, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int nb,
                            input bit glitch);
      for (int i = 0; i < nb; i++) begin
         dataps2 = bits[i];
         if (glitch) begin
            cyc(HALF / 4);
            clkps2 = 1'b0;
            cyc(FL - 2);
            clkps2 = 1'b1;
            cyc(HALF - HALF / 4 - (FL - 2));
         end else begin
            cyc(HALF);
         end
         clkps2 = 1'b0;
         cyc(HALF);
         clkps2 = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit flip,
                       input bit stop, input bit glitch);
      send_bits(mk(b, flip, stop), 11, glitch);
      dataps2 = 1'b1;
      cyc(HALF);
   endtask

   logic [7:0] q[$];

   // reference: prefixes set flags, any other byte is one event
   task automatic model(output int n, output logic [7:0] c,
                        output logic e, output logic r);
      logic pe, pr;
      pe = 0; pr = 0; n = 0; c = 0; e = 0; r = 0;
      foreach (q[i]) begin
         if (q[i] == 8'hE0) pe = 1;
         else if (q[i] == 8'hF0) pr = 1;
         else begin
            n++; c = q[i]; e = pe; r = pr; pe = 0; pr = 0;
         end
      end
   endtask

   task automatic run_q(input string tag);
      int i0, e0, n;
      logic [7:0] c;
      logic e, r;
      i0 = n_int;
      e0 = n_err;
      foreach (q[i]) send(q[i], 0, 1, 0);
      model(n, c, e, r);
      check({tag, "_int"}, 32'(n_int - i0), 32'(n));
      check({tag, "_err"}, 32'(n_err - e0), 32'd0);
      check({tag, "_code"}, 32'(ev.scancode), 32'(c));
      check({tag, "_ext"}, 32'(ev.extended), 32'(e));
      check({tag, "_rel"}, 32'(ev.released), 32'(r));
   endtask

   initial begin
      int i0, e0;
      logic [7:0] b;

      cyc(4);
      @(negedge clk);
      check("rst_code", 32'(ev.scancode), 32'd0);
      check("rst_ext", 32'(ev.extended), 32'd0);
      check("rst_rel", 32'(ev.released), 32'd0);
      check("rst_int", 32'(ev.kb_interrupt), 32'd0);
      check("rst_err", 32'(ev.frame_err), 32'd0);
      rst_n = 1'b1;
      cyc(20);

      q = '{8'h1C};
      run_q("plain1c");
      q = '{8'hE0, 8'hF0, 8'h75};
      run_q("extrel75");
      q = '{8'h75};
      run_q("plain75");

      i0 = n_int;
      e0 = n_err;
      send(8'hF0, 0, 1, 0);
      send(8'h33, 0, 0, 0);
      check("stop_err", 32'(n_err - e0), 32'd1);
      check("stop_int", 32'(n_int - i0), 32'd0);
      q = '{8'h1C};
      run_q("after_stop");

      i0 = n_int;
      e0 = n_err;
      send(8'hE0, 0, 1, 0);
      send_bits(mk(8'h5A, 0, 1), 5, 0);
      dataps2 = 1'b1;
      cyc(TO + 10);
      check("to_err", 32'(n_err - e0), 32'd1);
      check("to_int", 32'(n_int - i0), 32'd0);
      q = '{8'h29};
      run_q("after_to");

      i0 = n_int;
      e0 = n_err;
      send(8'h1C, 1, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
      check("par_err", 32'(n_err - e0), 32'd1);
      check("par_int", 32'(n_int - i0), 32'd0);
`else
      check("par_err", 32'(n_err - e0), 32'd0);
      check("par_int", 32'(n_int - i0), 32'd1);
      check("par_code", 32'(ev.scancode), 32'h1C);
`endif

      i0 = n_int;
      e0 = n_err;
      send(8'h4B, 0, 1, 1);
      check("glitch_int", 32'(n_int - i0), 32'd1);
      check("glitch_err", 32'(n_err - e0), 32'd0);
      check("glitch_code", 32'(ev.scancode), 32'h4B);

      send_bits(mk(8'h12, 0, 1), 4, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_code", 32'(ev.scancode), 32'd0);
      check("mrst_int", 32'(ev.kb_interrupt), 32'd0);
      check("mrst_err", 32'(ev.frame_err), 32'd0);
      dataps2 = 1'b1;
      clkps2 = 1'b1;
      cyc(3);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(20);
      q = '{8'h12};
      run_q("post_rst");

      for (int k = 0; k < 8; k++) begin
         q = {};
         if ($urandom_range(0, 1)) q.push_back(8'hE0);
         if ($urandom_range(0, 1)) q.push_back(8'hF0);
         b = 8'($urandom_range(0, 255));
         if (b == 8'hE0 || b == 8'hF0) b = b ^ 8'h01;
         q.push_back(b);
         run_q("rand");
      end

      check("strobe_overlap", 32'(n_both), 32'd0);
      check("strobe_width", 32'(n_wide), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
